// File: rtl/ofm_packer_mp.sv
// ofm_packer_mp: packs NUM_PORTS signed result streams into AXIS words and ping-pong bursts for the AXI write master; ports: op_start/ofm_addr_base/ofm_v/ofm_data/end_conv in, axis_* and wmst_* handshakes, write_buffer_wait/overflow/flush_done status out
module ofm_packer_mp #(
  parameter int NUM_PORTS      = 2,
  parameter int OUT_DATA_WIDTH = 25,
  parameter int LANE_WIDTH     = 32,
  parameter int AXIS_WIDTH     = 512,
  parameter int BURST_WORDS    = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                op_start,
  input  logic [63:0]                         ofm_addr_base,
  input  logic [NUM_PORTS-1:0]                ofm_v,
  input  logic [NUM_PORTS*OUT_DATA_WIDTH-1:0] ofm_data,
  input  logic                                end_conv,
  output logic                                axis_tvalid,
  input  logic                                axis_tready,
  output logic [AXIS_WIDTH-1:0]               axis_tdata,
  output logic                                wmst_req,
  input  logic                                wmst_done,
  output logic [63:0]                         wmst_offset,
  output logic [63:0]                         wmst_xfer_size,
  output logic                                write_buffer_wait,
  output logic                                overflow,
  output logic                                flush_done
);
  localparam int LANES = AXIS_WIDTH / LANE_WIDTH;
  localparam int LPW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
  localparam logic [63:0] WORD_BYTES = 64'(AXIS_WIDTH / 8);
  localparam logic [63:0] BURST_BYTES = 64'(BURST_WORDS) * WORD_BYTES;
  localparam logic [AW-1:0] LAST_WORD = AW'(BURST_WORDS - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BURST_WORDS);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ctl_t;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_STREAM, W_WAIT_DONE} wst_t;
  ctl_t ctl;
  wst_t wst;
  logic [63:0] base;
  logic [31:0] burst_idx;
  logic [AXIS_WIDTH-1:0] cur_word, word_a, word_b, commit_word;
  logic [LPW-1:0] lane_ptr, lane_nxt;
  logic [AW-1:0] word_ptr, rd_ptr;
  logic fill_bank, send_bank, wrap, wbw, accept, flush_commit, commit;
  logic [1:0] bank_full, rel;
  logic [AW:0] bank_cnt [2];
  logic signed [OUT_DATA_WIDTH-1:0] v;
  logic [AXIS_WIDTH-1:0] mem [2**(AW+1)];
  // valid ports fill lanes in index order; a wrap sends later values into word_b
  always_comb begin
    int lp;
    word_a = cur_word;
    word_b = '0;
    wrap = 1'b0;
    v = '0;
    lp = int'(lane_ptr);
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ofm_v[k]) begin
        v = ofm_data[k*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
        if (wrap) word_b[lp*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(v);
        else word_a[lp*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(v);
        wrap = wrap | (lp == LANES - 1);
        lp = (lp == LANES - 1) ? 0 : lp + 1;
      end
    end
    lane_nxt = LPW'(lp);
  end
  assign wbw = bank_full[fill_bank];
  assign write_buffer_wait = wbw;
  assign accept = (ctl == RUN) && (|ofm_v) && !wbw;
  assign flush_commit = (ctl == FLUSH) && (lane_ptr != '0) && !wbw;
  assign commit = (accept && wrap) || flush_commit;
  assign commit_word = flush_commit ? cur_word : word_a;
  // a bank released this cycle no longer blocks the end of the flush
  assign rel = (wst == W_WAIT_DONE && wmst_done) ? (2'b01 << send_bank) : 2'b00;
  always_ff @(posedge clk) begin
    if (commit) mem[{fill_bank, word_ptr}] <= commit_word;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl <= IDLE;
      wst <= W_IDLE;
      base <= '0;
      burst_idx <= '0;
      cur_word <= '0;
      lane_ptr <= '0;
      word_ptr <= '0;
      rd_ptr <= '0;
      fill_bank <= 1'b0;
      send_bank <= 1'b0;
      bank_full <= '0;
      bank_cnt[0] <= '0;
      bank_cnt[1] <= '0;
      axis_tvalid <= 1'b0;
      axis_tdata <= '0;
      wmst_req <= 1'b0;
      wmst_offset <= '0;
      wmst_xfer_size <= '0;
      overflow <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      wmst_req <= 1'b0;
      flush_done <= 1'b0;
      if ((ctl == IDLE || ctl == DONE) && op_start) begin
        ctl <= RUN;
        base <= ofm_addr_base;
        overflow <= 1'b0;
        lane_ptr <= '0;
        word_ptr <= '0;
        cur_word <= '0;
        burst_idx <= '0;
        fill_bank <= 1'b0;
        send_bank <= 1'b0;
      end
      if (ctl == RUN) begin
        if ((|ofm_v) && wbw) overflow <= 1'b1;
        if (accept) begin
          lane_ptr <= lane_nxt;
          cur_word <= wrap ? word_b : word_a;
        end
        if (end_conv) ctl <= FLUSH;
      end
      if (flush_commit) begin
        lane_ptr <= '0;
        cur_word <= '0;
      end
      if (ctl == FLUSH && lane_ptr == '0) begin
        if (word_ptr != '0) begin
          bank_full[fill_bank] <= 1'b1;
          bank_cnt[fill_bank] <= {1'b0, word_ptr};
          fill_bank <= ~fill_bank;
          word_ptr <= '0;
        end else if ((bank_full & ~rel) == 2'b00) begin
          ctl <= DONE;
          flush_done <= 1'b1;
        end
      end
      if (commit) begin
        if (word_ptr == LAST_WORD) begin
          bank_full[fill_bank] <= 1'b1;
          bank_cnt[fill_bank] <= FULL_CNT;
          fill_bank <= ~fill_bank;
          word_ptr <= '0;
        end else begin
          word_ptr <= word_ptr + 1'b1;
        end
      end
      case (wst)
        W_IDLE: if (bank_full[send_bank]) begin
          wst <= W_REQ;
          wmst_req <= 1'b1;
          wmst_offset <= base + {32'd0, burst_idx} * BURST_BYTES;
          wmst_xfer_size <= 64'(bank_cnt[send_bank]) * WORD_BYTES;
        end
        W_REQ: begin
          wst <= W_STREAM;
          axis_tvalid <= 1'b1;
          axis_tdata <= mem[{send_bank, AW'(0)}];
          rd_ptr <= '0;
        end
        W_STREAM: if (axis_tready) begin
          if ({1'b0, rd_ptr} + (AW+1)'(1) == bank_cnt[send_bank]) begin
            axis_tvalid <= 1'b0;
            wst <= W_WAIT_DONE;
          end else begin
            rd_ptr <= rd_ptr + 1'b1;
            axis_tdata <= mem[{send_bank, rd_ptr + 1'b1}];
          end
        end
        W_WAIT_DONE: if (wmst_done) begin
          wst <= W_IDLE;
          bank_full[send_bank] <= 1'b0;
          send_bank <= ~send_bank;
          burst_idx <= burst_idx + 1'b1;
        end
      endcase
    end
  end
endmodule
